// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART receive front end.
//   - rx_state_t : receiver FSM state encoding (IDLE, START, DATA, PARITY, STOP, BREAK)
//   - DEFAULT_CLKS_PER_BIT / DEFAULT_DATA_WIDTH : default frame timing and payload width
//   The PARITY state is only entered when UART_RX_PARITY_EN is defined. It stays in the
//   encoding unconditionally so the state type is identical in every build.

package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_DATA_WIDTH   = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte_sync_2ff.sv
// sync_2ff
//   Generic two-flop synchroniser for a single asynchronous input.
//   Both flops load RESET_VALUE on a synchronous reset. This lets an idle-high line
//   come out of reset already at its idle level.
//   Ports:
//     clk  - destination clock, rising edge
//     rst  - synchronous active-high reset
//     d    - asynchronous input
//     q    - synchronised output (two clk cycles of latency)

module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   8N1 serial receiver. It turns frames on the rx pin into a byte plus a one-cycle
//   write strobe. we/data_out drive the downstream register's we/data_in directly.
//   Optional feature macro: UART_RX_PARITY_EN
//     When defined, one even-parity bit follows the data bits. A mismatch pulses parity_err.
//   Ports:
//     clk        - system clock, rising edge
//     rst        - synchronous active-high reset
//     rx         - asynchronous serial input, idle high
//     we         - one-cycle strobe, data_out holds a new byte
//     data_out   - last correctly received byte
//     frame_err  - one-cycle pulse when the stop bit is sampled low
//     parity_err - (UART_RX_PARITY_EN only) one-cycle pulse on parity mismatch

module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  we,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    // CLKS_PER_BIT must be at least 4 so the half-bit point lies strictly inside a bit.
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_TICK = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    rx_state_t             state;
    rx_state_t             state_next;

    logic                  rxs;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic [BIT_W-1:0]      bit_idx;
    logic [BIT_W-1:0]      bit_idx_next;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [DATA_WIDTH-1:0] data_next;
    logic                  we_next;
    logic                  frame_err_next;
`ifdef UART_RX_PARITY_EN
    logic                  par_bad;
    logic                  par_bad_next;
    logic                  parity_err_next;
`endif

    logic tick;
    logic half;

    assign tick = (cnt == CNT_TICK);
    assign half = (cnt == CNT_HALF);

    sync_2ff #(
        .RESET_VALUE(1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Timing is anchored at the start-bit midpoint. Every later bit tick then falls mid-bit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_next = START;
                end
            end
            START: begin
                if (half) begin
                    state_next = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && (bit_idx == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_next = rxs ? IDLE : BREAK;
                end
            end
            BREAK: begin
                // A held-low line must go high again before a new start bit is accepted.
                if (rxs) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counter, shifter and result decisions. The strobes are registered, so they appear
    // in the cycle after the deciding tick, and data_out moves in that same cycle.
    always_comb begin
        cnt_next       = tick ? '0 : cnt + CNT_W'(1);
        bit_idx_next   = bit_idx;
        shift_next     = shift;
        data_next      = data_out;
        we_next        = 1'b0;
        frame_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_next    = par_bad;
        parity_err_next = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_next     = '0;
                bit_idx_next = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_next = 1'b0;
`endif
            end
            START: begin
                if (half) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                // Line order is LSB first, so each new bit enters at the MSB and moves down.
                if (tick) begin
                    shift_next                 = shift >> 1;
                    shift_next[DATA_WIDTH-1]   = rxs;
                    bit_idx_next               = bit_idx + BIT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                // Even parity: payload ones plus the parity bit must give an even count.
                if (tick) begin
                    par_bad_next = (rxs != (^shift));
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (!rxs) begin
                        frame_err_next = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad) begin
                        parity_err_next = 1'b1;
`endif
                    end else begin
                        we_next   = 1'b1;
                        data_next = shift;
                    end
                end
            end
            BREAK: begin
                cnt_next = '0;
            end
            default: begin
                cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data_out  <= '0;
            we        <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            cnt       <= cnt_next;
            bit_idx   <= bit_idx_next;
            shift     <= shift_next;
            data_out  <= data_next;
            we        <= we_next;
            frame_err <= frame_err_next;
`ifdef UART_RX_PARITY_EN
            par_bad    <= par_bad_next;
            parity_err <= parity_err_next;
`endif
        end
    end

endmodule
